// File: rtl/adb_kbd_device.sv
// Device-side ADB keyboard: decodes command bytes, answers Talk with register
// contents, absorbs Listen payloads and buffers key events in a small FIFO.
//
// state  | meaning
// IDLE   | waiting for a command byte; SRQ may be asserted
// LISTEN | consuming Listen payload bytes until lst_last
// TALK   | presenting the two-byte response on the tx handshake
module adb_kbd_device #(
    parameter logic [3:0] DEF_ADDR    = 4'd2,
    parameter logic [7:0] DEF_HANDLER = 8'h01,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic       key_up,
    input  logic [6:0] key_code,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    input  logic       lst_valid,
    input  logic [7:0] lst_byte,
    input  logic       lst_last,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       talk_none,
    output logic       srq,
    output logic       overflow
);
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LISTEN, ST_TALK} state_t;

    state_t          state, next_state;
    logic [3:0]      addr;
    logic [7:0]      handler;
    logic            srq_en;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_nxt;
    logic [CW-1:0]   count;
    logic [7:0]      resp1;
    logic [1:0]      lst_cnt;
    logic            lst_reg3;
    logic [7:0]      lst_b0, lst_b1, b1_eff;

    logic            do_reset, do_flush, do_none;
    logic [CW-1:0]   pop_n;
    logic [7:0]      resp0_d, resp1_d;
    logic            flushing, push_acc, lst_apply;

    assign rd_nxt    = rd_ptr + PW'(1);
    assign flushing  = do_reset | do_flush;
    assign push_acc  = key_valid & (flushing | ((count - pop_n) < CW'(FIFO_DEPTH)));
    assign srq       = srq_en & (count != '0) & (state == ST_IDLE);
    assign b1_eff    = (lst_cnt == 2'd1) ? lst_byte : lst_b1;
    assign lst_apply = (state == ST_LISTEN) & lst_valid & lst_last & lst_reg3 & (lst_cnt != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_reset   = 1'b0;
        do_flush   = 1'b0;
        do_none    = 1'b0;
        pop_n      = '0;
        resp0_d    = 8'hFF;
        resp1_d    = 8'hFF;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_byte[3:0] == 4'b0000) begin
                        do_reset = 1'b1;
                    end else if (cmd_byte[7:4] == addr) begin
                        case (cmd_byte[3:2])
                            2'b00: do_flush = (cmd_byte[1:0] == 2'b01);
                            2'b10: next_state = ST_LISTEN;
                            2'b11: begin
                                case (cmd_byte[1:0])
                                    2'd0: begin
                                        if (count == '0) begin
                                            do_none = 1'b1;
                                        end else begin
                                            next_state = ST_TALK;
                                            resp0_d    = fifo_mem[rd_ptr];
                                            if (count >= CW'(2)) begin
                                                resp1_d = fifo_mem[rd_nxt];
                                                pop_n   = CW'(2);
                                            end else begin
                                                pop_n   = CW'(1);
                                            end
                                        end
                                    end
                                    2'd1: do_none = 1'b1;
                                    2'd2: next_state = ST_TALK;
                                    default: begin
                                        next_state = ST_TALK;
                                        resp0_d    = {2'b01, srq_en, 1'b0, addr};
                                        resp1_d    = handler;
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_LISTEN: if (lst_valid && lst_last) next_state = ST_IDLE;
            ST_TALK:   if (tx_valid && tx_ready && tx_last) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid  <= 1'b0;
            tx_byte   <= 8'h00;
            tx_last   <= 1'b0;
            resp1     <= 8'h00;
            talk_none <= 1'b0;
        end else begin
            talk_none <= do_none;
            if (state == ST_IDLE && next_state == ST_TALK) begin
                tx_valid <= 1'b1;
                tx_byte  <= resp0_d;
                tx_last  <= 1'b0;
                resp1    <= resp1_d;
            end else if (state == ST_TALK && tx_valid && tx_ready) begin
                if (tx_last) begin
                    tx_valid <= 1'b0;
                    tx_byte  <= 8'h00;
                    tx_last  <= 1'b0;
                end else begin
                    tx_byte  <= resp1;
                    tx_last  <= 1'b1;
                end
            end
        end
    end

    // Listen payload capture; only the first two bytes matter for reg 3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lst_cnt  <= 2'd0;
            lst_reg3 <= 1'b0;
            lst_b0   <= 8'h00;
            lst_b1   <= 8'h00;
        end else if (state != ST_LISTEN) begin
            lst_cnt  <= 2'd0;
            lst_reg3 <= (cmd_byte[1:0] == 2'b11);
        end else if (lst_valid) begin
            if (lst_cnt == 2'd0) lst_b0 <= lst_byte;
            if (lst_cnt == 2'd1) lst_b1 <= lst_byte;
            if (lst_cnt != 2'd2) lst_cnt <= lst_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr    <= DEF_ADDR;
            handler <= DEF_HANDLER;
            srq_en  <= 1'b1;
        end else if (do_reset) begin
            addr    <= DEF_ADDR;
            handler <= DEF_HANDLER;
            srq_en  <= 1'b1;
        end else if (lst_apply) begin
            case (b1_eff)
                8'hFE: addr <= lst_b0[3:0];
                8'h00: begin
                    srq_en <= lst_b0[5];
                    addr   <= lst_b0[3:0];
                end
                8'h01, 8'h02, 8'h03: handler <= b1_eff;
                default: ;
            endcase
        end
    end

    // A flush and a key event in the same cycle leave just the new key queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PW'(1);
            if (flushing) begin
                rd_ptr <= wr_ptr;
                count  <= push_acc ? CW'(1) : '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(pop_n);
                count  <= count - pop_n + (push_acc ? CW'(1) : CW'(0));
            end
            if (do_reset)                    overflow <= 1'b0;
            else if (key_valid && !push_acc) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr] <= {key_up, key_code};
    end
endmodule
